pwm_multi_channel: RTL and testbench

- Parametrised successor to the single-channel configurable PWM: NCH independent duty channels share one prescaler and one period counter.
- Adds edge-aligned and center-aligned modes, per-channel polarity, a true 0%..100% duty range, and shadow registers, so configuration changes never glitch mid-period.
- Sits between a register file or control logic and motor, LED or power-stage pins; the period_start pulse can trigger ADC sampling.

---
 rtl/pwm_multi_channel_if.sv | 24 ++
 rtl/pwm_multi_channel.sv | 99 +++++++++
 tb/tb_pwm_multi_channel.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/pwm_multi_channel_if.sv
// Control/status bundle for pwm_multi_channel: run configuration in, PWM pins and period marker out.
interface pwm_multi_channel_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8,
    parameter int PRE_W = 16
);
    logic                       en;
    logic [PRE_W-1:0]           prescaler;
    logic                       center_mode;
    logic [NCH*(CNT_W+1)-1:0]   duty;
    logic [NCH-1:0]             polarity;
    logic [NCH-1:0]             pwm_out;
    logic                       period_start;

    modport master (
        output en, prescaler, center_mode, duty, polarity,
        input  pwm_out, period_start
    );

    modport slave (
        input  en, prescaler, center_mode, duty, polarity,
        output pwm_out, period_start
    );
endinterface

// File: rtl/pwm_multi_channel.sv
// NCH-channel PWM sharing one prescaler and period counter; edge or center aligned,
// with shadowed configuration that only changes at the period boundary.
module pwm_multi_channel #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8,
    parameter int PRE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pwm_multi_channel_if.slave    bus
);
    localparam logic [CNT_W-1:0] TOP      = '1;
    localparam logic [0:0]       DIR_UP   = 1'b0;
    localparam logic [0:0]       DIR_DOWN = 1'b1;

    logic [PRE_W-1:0]            pre_cnt;
    logic [PRE_W-1:0]            pre_sh;
    logic [CNT_W-1:0]            cnt;
    logic [CNT_W-1:0]            cnt_nxt;
    logic [0:0]                  dir;
    logic [0:0]                  dir_nxt;
    logic                        center_sh;
    logic [NCH-1:0][CNT_W:0]     duty_sh;
    logic [NCH-1:0]              pol_sh;
    logic [NCH-1:0]              raw;
    logic [NCH-1:0]              pwm_q;
    logic                        ps_q;
    logic                        tick;
    logic                        update;

    assign tick = (pre_cnt == pre_sh);

    always_comb begin
        cnt_nxt = cnt;
        dir_nxt = dir;
        if (tick) begin
            if (!center_sh) begin
                cnt_nxt = (cnt == TOP) ? '0 : cnt + CNT_W'(1);
            end else if (dir == DIR_UP) begin
                if (cnt == TOP) begin
                    cnt_nxt = cnt - CNT_W'(1);
                    dir_nxt = DIR_DOWN;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end else begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) dir_nxt = DIR_UP;
            end
        end
    end

    // Every tick moves cnt, so landing on zero is exactly the period boundary.
    assign update = tick && (cnt_nxt == '0);

    // Duty is one bit wider than cnt so duty >= 2^CNT_W compares true for every count.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign raw[i] = ({1'b0, cnt} < duty_sh[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt   <= '0;
            cnt       <= '0;
            dir       <= DIR_UP;
            pre_sh    <= '0;
            center_sh <= 1'b0;
            duty_sh   <= '0;
            pol_sh    <= '0;
            pwm_q     <= '0;
            ps_q      <= 1'b0;
        end else if (!bus.en) begin
            pre_cnt   <= '0;
            cnt       <= '0;
            dir       <= DIR_UP;
            pre_sh    <= bus.prescaler;
            center_sh <= bus.center_mode;
            duty_sh   <= bus.duty;
            pol_sh    <= bus.polarity;
            pwm_q     <= bus.polarity;
            ps_q      <= 1'b0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
            cnt     <= cnt_nxt;
            dir     <= dir_nxt;
            pwm_q   <= raw ^ pol_sh;
            ps_q    <= update;
            if (update) begin
                pre_sh    <= bus.prescaler;
                center_sh <= bus.center_mode;
                duty_sh   <= bus.duty;
                pol_sh    <= bus.polarity;
            end
        end
    end

    assign bus.pwm_out      = pwm_q;
    assign bus.period_start = ps_q;
endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench for pwm_multi_channel: time-based reference model plus directed pulse/period measurements.
module tb_pwm_multi_channel;
    localparam int NCH = 2;
    localparam int CW  = 4;
    localparam int PW  = 8;
    localparam int DW  = CW + 1;
    localparam int TOP = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    bit   chk_on = 1'b0;

    pwm_multi_channel_if #(.NCH(NCH), .CNT_W(CW), .PRE_W(PW)) bus();

    pwm_multi_channel #(.NCH(NCH), .CNT_W(CW), .PRE_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: position in the period is clocks-since-boundary; count value follows arithmetically.
    int             m_t = 0;
    int             m_p = 0;
    bit             m_c = 1'b0;
    int             m_d[NCH] = '{default: 0};
    bit [NCH-1:0]   m_pol = '0;
    bit [NCH-1:0]   exp_pwm = '0;
    bit             exp_ps = 1'b0;

    task load_sh();
        m_p = int'(bus.prescaler);
        m_c = bus.center_mode;
        for (int i = 0; i < NCH; i++) m_d[i] = int'(bus.duty[i*DW +: DW]);
        m_pol = bus.polarity;
    endtask

    always @(posedge clk or posedge rst) begin : model
        int k, c, plen;
        if (rst) begin
            m_t = 0; m_p = 0; m_c = 1'b0; m_pol = '0; exp_pwm = '0; exp_ps = 1'b0;
            for (int i = 0; i < NCH; i++) m_d[i] = 0;
        end else if (!bus.en) begin
            m_t = 0;
            load_sh();
            exp_pwm = bus.polarity;
            exp_ps  = 1'b0;
        end else begin
            k = m_t / (m_p + 1);
            if (m_c) begin
                plen = (m_p + 1) * 2 * TOP;
                c    = (k <= TOP) ? k : 2 * TOP - k;
            end else begin
                plen = (m_p + 1) * (TOP + 1);
                c    = k;
            end
            for (int i = 0; i < NCH; i++) exp_pwm[i] = (c < m_d[i]) ^ m_pol[i];
            m_t++;
            exp_ps = (m_t == plen);
            if (exp_ps) begin
                m_t = 0;
                load_sh();
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            checks++;
            if (bus.pwm_out !== exp_pwm || bus.period_start !== exp_ps) begin
                errors++;
                $display("FAIL model @%0t: pwm_out=%b want %b, period_start=%b want %b",
                         $time, bus.pwm_out, exp_pwm, bus.period_start, exp_ps);
            end
        end
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic cfg(bit e, int p, bit c, int d0, int d1, bit [1:0] pol);
        @(negedge clk);
        bus.en          = e;
        bus.prescaler   = PW'(p);
        bus.center_mode = c;
        bus.duty        = {DW'(d1), DW'(d0)};
        bus.polarity    = pol;
    endtask

    // Load shadows transparently for one clock, then raise en.
    task automatic start(int p, bit c, int d0, int d1, bit [1:0] pol);
        cfg(1'b0, p, c, d0, d1, pol);
        @(negedge clk);
        bus.en = 1'b1;
    endtask

    task automatic cnt_hi(int ch, int n, output int hi);
        hi = 0;
        repeat (n) begin
            @(negedge clk);
            hi += int'(bus.pwm_out[ch]);
        end
    endtask

    task automatic wait_ps(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.period_start && n < 500);
        if (!bus.period_start) chk("ps_timeout", 0, 1);
    endtask

    initial begin
        int n, hi;
        bus.en = 1'b0; bus.prescaler = '0; bus.center_mode = 1'b0; bus.duty = '0; bus.polarity = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_pwm", int'(bus.pwm_out), 0);
        chk("reset_ps", int'(bus.period_start), 0);
        chk_on = 1'b1;
        rst = 1'b0;

        // Edge aligned, P=0
        start(0, 1'b0, 4, 12, 2'b00);
        wait_ps(n);            chk("edge_first_ps", n, 16);
        chk("edge_pre_rise", int'(bus.pwm_out), 0);
        @(negedge clk);        chk("edge_rise", int'(bus.pwm_out), 3);
        wait_ps(n);            chk("edge_ps_partial", n, 15);
        wait_ps(n);            chk("edge_period", n, 16);
        cnt_hi(0, 32, hi);     chk("edge_hi_ch0", hi, 8);
        cnt_hi(1, 32, hi);     chk("edge_hi_ch1", hi, 24);

        // Center aligned, P=0 then P=1
        start(0, 1'b1, 3, 12, 2'b00);
        wait_ps(n);            chk("ctr_first_ps", n, 30);
        cnt_hi(0, 30, hi);     chk("ctr_hi_ch0", hi, 5);
        cnt_hi(1, 30, hi);     chk("ctr_hi_ch1", hi, 23);
        bus.prescaler = PW'(1);
        wait_ps(n);
        wait_ps(n);            chk("ctr_p1_period", n, 60);
        cnt_hi(0, 60, hi);     chk("ctr_p1_hi_ch0", hi, 10);

        // Shadowed duty and prescaler changes mid-period
        start(0, 1'b0, 4, 12, 2'b00);
        wait_ps(n);
        hi = 0;
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            if (j == 5) bus.duty = {DW'(12), DW'(10)};
            hi += int'(bus.pwm_out[0]);
        end
        chk("shadow_cur_period", hi, 4);
        cnt_hi(0, 16, hi);     chk("shadow_next_period", hi, 10);
        wait_ps(n);            chk("pre_before", n, 16);
        repeat (5) @(negedge clk);
        bus.prescaler = PW'(3);
        wait_ps(n);            chk("pre_cur_period", n + 5, 16);
        wait_ps(n);            chk("pre_next_period", n, 64);

        // Duty saturation and polarity
        start(0, 1'b0, 0, 16, 2'b00);
        cnt_hi(0, 48, hi);     chk("sat_d0_ch0", hi, 0);
        cnt_hi(1, 48, hi);     chk("sat_d16_ch1", hi, 48);
        start(0, 1'b0, 31, 16, 2'b00);
        cnt_hi(0, 48, hi);     chk("sat_d31_ch0", hi, 48);
        start(0, 1'b0, 0, 31, 2'b11);
        cnt_hi(0, 48, hi);     chk("sat_inv_d0", hi, 48);
        cnt_hi(1, 48, hi);     chk("sat_inv_d31", hi, 0);

        // Enable drop and restart
        start(0, 1'b0, 4, 12, 2'b10);
        wait_ps(n);
        repeat (6) @(negedge clk);
        bus.en = 1'b0;
        @(negedge clk);
        chk("idle_pwm", int'(bus.pwm_out), 2);
        chk("idle_ps", int'(bus.period_start), 0);
        repeat (3) @(negedge clk);
        bus.en = 1'b1;
        wait_ps(n);            chk("restart_ps", n, 16);

        // Asynchronous reset mid-period
        start(0, 1'b0, 31, 0, 2'b00);
        repeat (20) @(negedge clk);
        chk("pre_rst_pwm", int'(bus.pwm_out), 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_pwm", int'(bus.pwm_out), 0);
        chk("async_rst_ps", int'(bus.period_start), 0);
        @(negedge clk);
        rst = 1'b0;
        cnt_hi(0, 10, hi);     chk("post_rst_sh0", hi, 0);
        wait_ps(n);            chk("post_rst_ps", n, 6);
        cnt_hi(0, 16, hi);     chk("post_rst_loaded", hi, 16);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
